// File: rtl/fetch_stage_pkg.sv
// Shared types and RV32 constants for the fetch stage and the pipeline stages that consume it.
package fetch_stage_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;  // addi x0, x0, 0

    typedef logic [6:0] opcode_t;
    localparam opcode_t OPC_BRANCH = 7'b110_0011;
    localparam opcode_t OPC_JAL    = 7'b110_1111;
    localparam opcode_t OPC_JALR   = 7'b110_0111;

    // Fetch mode: SQUASH while stale responses from a redirected path are still due.
    localparam logic [0:0] MODE_RUN    = 1'b0;
    localparam logic [0:0] MODE_SQUASH = 1'b1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a synchronous clear.
// DEPTH must be a power of two (>= 2) so the pointer arithmetic wraps naturally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        fill     = wr_ptr_q - rd_ptr_q;
        empty    = (fill == '0);
        full     = (fill == (AW+1)'(DEPTH));
        count    = CW'(fill);
        pop_data = mem_q[rd_ptr_q[AW-1:0]];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Callers size their traffic so a push never meets a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !clr));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order requests under a shared credit
// budget, buffers returned words and squashes all wrong-path work on a redirect.
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iStall,
    input  logic        iBrTrue,
    input  logic [31:0] iBrTarget,
    output logic        oImemReqValid,
    input  logic        iImemReqReady,
    output logic [31:0] oImemReqAddr,
    input  logic        iImemRspValid,
    input  logic [31:0] iImemRspData,
    output if_id_t      oIF_ID
);
    // Handshakes: a request transfers on a cycle where oImemReqValid && iImemReqReady;
    // valid/addr hold until then. Responses arrive in order with no back-pressure.
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          run_q, run_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [0:0]    mode_q, mode_d;

    logic [CW:0]   credit_used;
    logic          req_fire, rsp_keep, out_valid, ibuf_pop;
    logic [31:0]   tag_pc;
    logic          tag_full, tag_empty;
    logic [CW-1:0] tag_count;
    logic [63:0]   ibuf_head;
    logic          ibuf_full, ibuf_empty;
    logic [CW-1:0] ibuf_count;

    always_comb begin
        run_d         = 1'b1;
        credit_used   = {1'b0, outstanding_q} + {1'b0, ibuf_count};
        oImemReqValid = run_q && !iBrTrue && (credit_used < (CW+1)'(FIFO_DEPTH));
        oImemReqAddr  = pc_q;
        req_fire      = oImemReqValid && iImemReqReady;
        // A response coinciding with a redirect is wrong-path as well.
        rsp_keep      = iImemRspValid && !iBrTrue && (mode_q == MODE_RUN);
        out_valid     = !ibuf_empty && !iBrTrue;
        ibuf_pop      = out_valid && !iStall;

        oIF_ID.valid  = out_valid;
        oIF_ID.pc     = out_valid ? ibuf_head[63:32] : '0;
        oIF_ID.instr  = out_valid ? ibuf_head[31:0]  : '0;

        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(iImemRspValid);
        drop_d        = drop_q;
        if (iBrTrue) begin
            pc_d   = iBrTarget & ~32'h3;
            drop_d = outstanding_q - CW'(iImemRspValid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'(INSTR_BYTES);
            end
            if (iImemRspValid && drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end

        mode_d = mode_q;
        case (mode_q)
            MODE_RUN:    if (drop_d != '0) mode_d = MODE_SQUASH;
            MODE_SQUASH: if (drop_d == '0) mode_d = MODE_RUN;
            default:     mode_d = MODE_RUN;
        endcase
    end

    // run_q gives the synchronous release: the first request goes out the cycle after nRst rises.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            run_q         <= 1'b0;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            mode_q        <= MODE_RUN;
        end else begin
            run_q         <= run_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            mode_q        <= mode_d;
        end
    end

    // Tags are never flushed: stale responses still pop their own tag before being dropped.
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tag_q (
        .clk       (iClk),
        .rst_n     (nRst),
        .clr       (1'b0),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (iImemRspValid),
        .pop_data  (tag_pc),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_ibuf (
        .clk       (iClk),
        .rst_n     (nRst),
        .clr       (iBrTrue),
        .push      (rsp_keep),
        .push_data ({tag_pc, iImemRspData}),
        .pop       (ibuf_pop),
        .pop_data  (ibuf_head),
        .full      (ibuf_full),
        .empty     (ibuf_empty),
        .count     (ibuf_count)
    );

    assert property (@(posedge iClk) disable iff (!nRst) !(iImemRspValid && tag_empty));
    assert property (@(posedge iClk) disable iff (!nRst) tag_count == outstanding_q);
    assert property (@(posedge iClk) disable iff (!nRst) !(req_fire && tag_full));
    assert property (@(posedge iClk) disable iff (!nRst) !(ibuf_full && outstanding_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a randomized memory model feeds the DUT, and a monitor checks
// the output stream against the architectural PC sequence implied by resets and redirects.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        stall, br;
    logic [31:0] br_target;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    if_id_t      if_id;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_next;
    int          cyc, min_lat, max_lat, mon_due;
    int          checks, failures, n_out;
    logic        hold_q;
    if_id_t      hold_val;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .iClk          (clk),
        .nRst          (n_rst),
        .iStall        (stall),
        .iBrTrue       (br),
        .iBrTarget     (br_target),
        .oImemReqValid (req_valid),
        .iImemReqReady (req_ready),
        .oImemReqAddr  (req_addr),
        .iImemRspValid (rsp_valid),
        .iImemRspData  (rsp_data),
        .oIF_ID        (if_id)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Program order after any reset/redirect: start, start+4, ... (wrapping at 2^32).
    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back({exp_next, mem_word(exp_next)});
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        exp_next = start;
        refill();
    endtask

    task automatic step(input logic rdy, input logic stl, input logic b, input logic [31:0] tgt);
        @(posedge clk);
        cyc++;
        #1;
        req_ready = rdy;
        stall     = stl;
        br        = b;
        br_target = tgt;
        rsp_valid = 1'b0;
        rsp_data  = $urandom;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        if (b) restart_stream({tgt[31:2], 2'b00});
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        n_rst     = 1'b0;
        rsp_valid = 1'b0;
        br        = 1'b0;
        stall     = 1'b0;
        req_ready = 1'b0;
        pend_q.delete();
        #1;
        check("reset_req_valid", {64'd0, req_valid}, 65'd0);
        check("reset_if_id", if_id, 65'd0);
        repeat (2) @(posedge clk);
        #3;
        n_rst = 1'b1;
        restart_stream(RESET_PC);
    endtask

    // Monitor: captures requests for the memory model and checks every presented output.
    always @(negedge clk) begin
        if (!n_rst) begin
            hold_q = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                check("credit_cap", {64'd0, (pend_q.size() + (rsp_valid ? 1 : 0) + 1) <= DEPTH}, 65'd1);
                mon_due = cyc + $urandom_range(min_lat, max_lat);
                if (pend_q.size() != 0 && pend_q[$].due >= mon_due) mon_due = pend_q[$].due + 1;
                pend_q.push_back('{addr: req_addr, due: mon_due});
            end
            if (br) begin
                check("flush_req_valid", {64'd0, req_valid}, 65'd0);
                check("flush_out_valid", {64'd0, if_id.valid}, 65'd0);
            end
            if (hold_q && !br) check("stall_hold", if_id, hold_val);
            if (if_id.valid) begin
                refill();
                check("out_pc_instr", {1'b0, if_id.pc, if_id.instr}, {1'b0, exp_q[0]});
                if (!stall) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
            hold_q   = if_id.valid && stall;
            hold_val = if_id;
        end
    end

    logic        got_req, got_out;
    logic [31:0] first_req, first_out;

    initial begin
        n_rst = 1'b0; stall = 1'b0; br = 1'b0; br_target = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        cyc = 0; checks = 0; failures = 0; n_out = 0;
        min_lat = 1; max_lat = 1; hold_q = 1'b0; hold_val = '0; exp_next = RESET_PC;

        // 1: reset, ready=1, latency 1
        apply_reset();
        step(1, 0, 0, 0); @(negedge clk);
        check("t1_c1_req", {req_valid, req_addr}, {1'b1, RESET_PC});
        check("t1_c1_out", {64'd0, if_id.valid}, 65'd0);
        step(1, 0, 0, 0); @(negedge clk);
        check("t1_c2_req", {req_valid, req_addr}, {1'b1, RESET_PC + 32'd4});
        check("t1_c2_out", {64'd0, if_id.valid}, 65'd0);
        step(1, 0, 0, 0); @(negedge clk);
        check("t1_c3_out", {if_id.valid, if_id.pc}, {1'b1, RESET_PC});
        repeat (12) step(1, 0, 0, 0);

        // 2: memory not ready for 5 cycles
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0); @(negedge clk);
            check("t2_hold_req", {req_valid, req_addr}, {1'b1, RESET_PC});
        end
        repeat (12) step(1, 0, 0, 0);

        // 3: stall with a full buffer
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0); @(negedge clk);
            if (i >= 3) check("t3_no_req", {64'd0, req_valid}, 65'd0);
        end
        check("t3_head", {if_id.valid, if_id.pc}, {1'b1, RESET_PC});
        repeat (12) step(1, 0, 0, 0);

        // 4: redirect to 0x100 with two requests outstanding
        min_lat = 4; max_lat = 4;
        apply_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0103);
        got_req = 1'b0; got_out = 1'b0; first_req = '0; first_out = '0;
        for (int i = 0; i < 30; i++) begin
            step(1, 0, 0, 0); @(negedge clk);
            if (!got_req && req_valid && req_ready) begin got_req = 1'b1; first_req = req_addr; end
            if (!got_out && if_id.valid) begin got_out = 1'b1; first_out = if_id.pc; end
        end
        check("t4_first_req", {got_req, first_req}, {1'b1, 32'h0000_0100});
        check("t4_first_out", {got_out, first_out}, {1'b1, 32'h0000_0100});

        // 5: redirect coincident with a response and a stall
        min_lat = 2; max_lat = 2;
        apply_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h2000_0003);
        step(1, 0, 0, 0); @(negedge clk);
        check("t5_next_req", {req_valid, req_addr}, {1'b1, 32'h2000_0000});
        repeat (15) step(1, 0, 0, 0);

        // Randomized traffic with redirects (one wraps the PC) and an async reset mid-burst
        min_lat = 1; max_lat = 4;
        apply_reset();
        step(1, 0, 1, 32'hFFFF_FFFA);
        n_out = 0;
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) begin
                apply_reset();
                step(1, 0, 0, 0); @(negedge clk);
                check("t6_restart_req", {req_valid, req_addr}, {1'b1, RESET_PC});
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 24) == 0, $urandom);
            end
        end
        repeat (10) step(1, 0, 0, 0);
        check("rand_progress", {64'd0, n_out > 200}, 65'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
